rangefinder_gpio_master: RTL and testbench
==========================================

# rangefinder_gpio_master

Avalon-MM master that drives the 8-bit bidirectional rangefinder GPIO slave from fabric logic, with no Nios involvement. It programs the direction register at startup and executes queued write commands (data, direction, bit-set, bit-clear). It also polls the data register at a fixed rate and reports per-bit rising and falling edges. It sits beside the GPIO slave in the rangefinder SOPC and gives the ranging FSM direct control of the sensor pins.

## Interface
- `POLL_DIV`, default 1000: poll period in clk cycles; must be ≥ 8.
- `RESET_DIR`, default 8'h00: direction value written once after reset.

- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  command operation: 0 = data, 1 = direction, 2 = set bits, 3 = clear bits.
- `cmd_data`  in  8  command operand.
- `poll_en`  in  1  enables the poll timer.
- `sample`  out  8  last polled pin value.
- `sample_valid`  out  1  high once the first poll has completed.
- `evt_valid`  out  1  one-cycle pulse when a poll shows any change.
- `evt_rise`  out  8  bits that went 0→1; valid with `evt_valid`.
- `evt_fall`  out  8  bits that went 1→0; valid with `evt_valid`.
- `avm_address`  out  3  slave register address.
- `avm_chipselect`  out  1  slave select.
- `avm_write_n`  out  1  active-low write strobe.
- `avm_writedata`  out  32  write data; bits 31:8 are always 0.
- `avm_readdata`  in  32  read data; only bits 7:0 are used.

## Operation
- Slave contract:
  - No waitrequest.
  - A write takes 1 cycle.
  - A read is chipselect=1 with write_n=1; readdata is registered, so read latency is 1 cycle.
- Op-to-address map:
  - op 0 → address 0.
  - op 1 → address 1.
  - op 2 → address 4.
  - op 3 → address 5.
- FSM states: `INIT`, `IDLE`, `WRITE`, `RD_ADDR`, `RD_CAP`.
  - `INIT` is the first state after reset. It writes `RESET_DIR` to address 1, then goes to `IDLE`.
  - In `IDLE`, an accepted command goes to `WRITE`. Otherwise, a pending poll goes to `RD_ADDR`.
  - `WRITE` drives one write cycle, then returns to `IDLE`.
  - `RD_ADDR` drives a read of address 0, then goes to `RD_CAP`.
  - `RD_CAP` captures `avm_readdata[7:0]`, then returns to `IDLE`.
- `cmd_ready` = (state == `IDLE`), combinational. The command is registered on acceptance.
- Priority: a command wins over a pending poll when both are present in `IDLE`. The poll stays pending.
- Poll timer:
  - Counts 0..`POLL_DIV`−1 while `poll_en` is high and wraps.
  - On wrap it sets `poll_pending`.
  - `poll_pending` clears on entry to `RD_ADDR`.
  - A wrap while already pending is absorbed; no overrun is counted.
  - When `poll_en` is low, the counter holds and a pending poll is still serviced.
- Capture:
  - `new` = readdata[7:0], `old` = `sample`.
  - `evt_rise` = new & ~old.
  - `evt_fall` = ~new & old.
  - `evt_valid` = sample_valid && (new != old).
- The first capture after reset sets `sample` and `sample_valid` and produces no event.
- Bus idle values: chipselect 0, write_n 1, address 0, writedata 0.

## Timing
- Reset values:
  - Bus outputs take their idle values.
  - `sample` = 0, `sample_valid` = 0.
  - `evt_valid` = 0, `evt_rise` = 0, `evt_fall` = 0.
  - `cmd_ready` = 0 (state `INIT`).
- `INIT` lasts exactly 1 cycle, so `cmd_ready` first rises in cycle 2 after reset release.
- Command latency:
  - Accept edge E; bus write occurs in cycle E+1; `cmd_ready` is high again in cycle E+2.
  - Back-to-back commands therefore run at one per 2 cycles.
- Poll latency:
  - Bus read occurs in the `RD_ADDR` cycle; data is captured on the edge ending `RD_CAP`.
  - `sample` and `evt_*` update in the cycle after `RD_CAP`.
  - `evt_valid` is high for exactly 1 cycle.
- `evt_rise`/`evt_fall` hold their values until the next capture that has `sample_valid` set.
- Reset mid-transaction (asynchronous):
  - Bus returns to idle immediately.
  - Captured state is lost.
  - `INIT` is re-run.
- A poll never interrupts a write, and a command never interrupts a read in progress.

## Structure
- Package `rangefinder_gpio_pkg` holds:
  - Register address constants: `GPIO_ADDR_DATA`=0, `GPIO_ADDR_DIR`=1, `GPIO_ADDR_SET`=4, `GPIO_ADDR_CLR`=5.
  - The `cmd_op` encodings.
  - The FSM state enum.
- Sub-module `rangefinder_gpio_poll_timer`:
  - Ports: clk, reset_n, `poll_en`, `clear` in; `poll_pending` out.
  - Counter width is $clog2(`POLL_DIV`).
- Everything else, including the FSM, bus drive and edge logic, lives in the top module.

## Test plan
- Reset release with `RESET_DIR`=8'h0F → cycle 1 shows chipselect=1, write_n=0, address=1, writedata=32'h0F; `cmd_ready` rises in cycle 2.
- Command op=2, data=8'h81 accepted → 1 write cycle at address 4 with writedata 32'h81; `cmd_ready` low for exactly 1 cycle.
- `POLL_DIV`=8, model returns 8'h00 then 8'h05 → first poll: `sample_valid`=1, no event. Second poll: `evt_valid` pulse with `evt_rise`=8'h05, `evt_fall`=0.
- Model returns 8'h05 then 8'h04 → `evt_fall`=8'h01, `evt_rise`=0; two equal consecutive reads → no `evt_valid`.
- `cmd_valid` held high in the same cycle the poll wrap lands → write issued first, then read; polls spaced exactly `POLL_DIV` cycles apart with no extra poll.
- `reset_n` asserted during `RD_ADDR` → chipselect drops immediately and `sample_valid`=0; after release, `INIT` write repeats and the next poll raises no event.

Source files
------------

// File: rtl/rangefinder_gpio_pkg.sv
// Shared register map, command encodings and FSM states for the
// rangefinder GPIO bus master.
package rangefinder_gpio_pkg;

  localparam logic [2:0] GPIO_ADDR_DATA = 3'd0;
  localparam logic [2:0] GPIO_ADDR_DIR  = 3'd1;
  localparam logic [2:0] GPIO_ADDR_SET  = 3'd4;
  localparam logic [2:0] GPIO_ADDR_CLR  = 3'd5;

  typedef enum logic [1:0] {
    OP_DATA = 2'd0,
    OP_DIR  = 2'd1,
    OP_SET  = 2'd2,
    OP_CLR  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    RD_ADDR,
    RD_CAP
  } state_e;

  function automatic logic [2:0] op_to_addr(input cmd_op_e op);
    logic [2:0] addr;
    case (op)
      OP_DATA: addr = GPIO_ADDR_DATA;
      OP_DIR:  addr = GPIO_ADDR_DIR;
      OP_SET:  addr = GPIO_ADDR_SET;
      default: addr = GPIO_ADDR_CLR;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/rangefinder_gpio_poll_timer.sv
// Free-running poll divider; raises poll_pending on each wrap and holds it
// until the master starts the read.
module rangefinder_gpio_poll_timer #(
  parameter int POLL_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic poll_en,
  input  logic clear,
  output logic poll_pending
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          wrap;

  // A wrap while a poll is already pending simply re-sets the flag.
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    wrap      = poll_en && (cnt_q == LAST);
    if (poll_en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    if (wrap) begin
      pending_d = 1'b1;
    end
    if (clear) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign poll_pending = pending_q;

endmodule

// File: rtl/rangefinder_gpio_master.sv
// Avalon-MM master for the rangefinder GPIO slave: programs direction at
// startup, executes queued writes and polls pins for edge events.
module rangefinder_gpio_master
  import rangefinder_gpio_pkg::*;
#(
  parameter int          POLL_DIV  = 1000,
  parameter logic [7:0]  RESET_DIR = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  input  logic        poll_en,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic        evt_valid,
  output logic [7:0]  evt_rise,
  output logic [7:0]  evt_fall,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  state_e     state_q, state_d;
  cmd_op_e    cmd_op_q, cmd_op_d;
  logic [7:0] cmd_data_q, cmd_data_d;
  logic [7:0] sample_q, sample_d;
  logic       sample_valid_q, sample_valid_d;
  logic       evt_valid_q, evt_valid_d;
  logic [7:0] evt_rise_q, evt_rise_d;
  logic [7:0] evt_fall_q, evt_fall_d;

  logic       poll_pending;
  logic       poll_clear;
  logic       bus_cs;
  logic       bus_write_n;
  logic [2:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] rd_byte;
  logic       unused_rd_hi;

  assign rd_byte      = avm_readdata[7:0];
  assign unused_rd_hi = ^avm_readdata[31:8];

  rangefinder_gpio_poll_timer #(
    .POLL_DIV (POLL_DIV)
  ) u_poll_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .poll_en      (poll_en),
    .clear        (poll_clear),
    .poll_pending (poll_pending)
  );

  // Next-state, bus drive and capture/edge logic; commands beat polls in IDLE.
  always_comb begin
    state_d        = state_q;
    cmd_op_d       = cmd_op_q;
    cmd_data_d     = cmd_data_q;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    evt_valid_d    = 1'b0;
    evt_rise_d     = evt_rise_q;
    evt_fall_d     = evt_fall_q;
    cmd_ready      = 1'b0;
    poll_clear     = 1'b0;
    bus_cs         = 1'b0;
    bus_write_n    = 1'b1;
    bus_addr       = GPIO_ADDR_DATA;
    bus_wdata      = 8'h00;

    case (state_q)
      INIT: begin
        bus_cs      = 1'b1;
        bus_write_n = 1'b0;
        bus_addr    = GPIO_ADDR_DIR;
        bus_wdata   = RESET_DIR;
        state_d     = IDLE;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_op_d   = cmd_op_e'(cmd_op);
          cmd_data_d = cmd_data;
          state_d    = WRITE;
        end else if (poll_pending) begin
          poll_clear = 1'b1;
          state_d    = RD_ADDR;
        end
      end
      WRITE: begin
        bus_cs      = 1'b1;
        bus_write_n = 1'b0;
        bus_addr    = op_to_addr(cmd_op_q);
        bus_wdata   = cmd_data_q;
        state_d     = IDLE;
      end
      RD_ADDR: begin
        bus_cs   = 1'b1;
        bus_addr = GPIO_ADDR_DATA;
        state_d  = RD_CAP;
      end
      RD_CAP: begin
        sample_d       = rd_byte;
        sample_valid_d = 1'b1;
        if (sample_valid_q) begin
          evt_rise_d  = rd_byte & ~sample_q;
          evt_fall_d  = ~rd_byte & sample_q;
          evt_valid_d = (rd_byte != sample_q);
        end
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= INIT;
      cmd_op_q       <= OP_DATA;
      cmd_data_q     <= 8'h00;
      sample_q       <= 8'h00;
      sample_valid_q <= 1'b0;
      evt_valid_q    <= 1'b0;
      evt_rise_q     <= 8'h00;
      evt_fall_q     <= 8'h00;
    end else begin
      state_q        <= state_d;
      cmd_op_q       <= cmd_op_d;
      cmd_data_q     <= cmd_data_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      evt_valid_q    <= evt_valid_d;
      evt_rise_q     <= evt_rise_d;
      evt_fall_q     <= evt_fall_d;
    end
  end

  // The state register sits in INIT during reset, so the bus is forced idle
  // by reset_n itself rather than waiting for the first clock edge.
  assign avm_chipselect = bus_cs & reset_n;
  assign avm_write_n    = bus_write_n | ~reset_n;
  assign avm_address    = reset_n ? bus_addr : GPIO_ADDR_DATA;
  assign avm_writedata  = {24'h000000, (reset_n ? bus_wdata : 8'h00)};

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign evt_valid    = evt_valid_q;
  assign evt_rise     = evt_rise_q;
  assign evt_fall     = evt_fall_q;

endmodule

// File: tb/tb_rangefinder_gpio_master.sv
// Directed scoreboard bench for rangefinder_gpio_master with a registered
// GPIO slave model answering reads from pinValue.
module tb_rangefinder_gpio_master;

  localparam int         POLL_DIV  = 8;
  localparam logic [7:0] RESET_DIR = 8'h0F;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wrExp_t;

  typedef struct {
    int         due;
    logic [7:0] value;
    logic       prevValid;
    logic       evtExp;
    logic [7:0] rise;
    logic [7:0] fall;
  } capExp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_data = 8'h00;
  logic        poll_en = 1'b0;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        evt_valid;
  logic [7:0]  evt_rise;
  logic [7:0]  evt_fall;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;

  logic [7:0]  pinValue = 8'h00;
  logic [7:0]  modelSample = 8'h00;
  logic        modelValid = 1'b0;
  wrExp_t      wrQ[$];
  capExp_t     capQ[$];
  int          cycleCount = 0;
  int          readCount = 0;
  int          lastReadCycle = 0;
  int          lastWriteCycle = 0;
  int          evtCount = 0;
  int          assertCount = 0;
  int          failCount = 0;

  rangefinder_gpio_master #(
    .POLL_DIV  (POLL_DIV),
    .RESET_DIR (RESET_DIR)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .poll_en        (poll_en),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .evt_valid      (evt_valid),
    .evt_rise       (evt_rise),
    .evt_fall       (evt_fall),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Slave model: registered readdata, one cycle of read latency.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n) avm_readdata <= {24'h0, pinValue};
  end

  function automatic logic [2:0] tbAddr(input logic [1:0] op);
    case (op)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor: checks bus writes, predicts captures from each read.
  always @(negedge clk) begin
    if (!reset_n) begin
      capQ.delete();
      modelValid  = 1'b0;
      modelSample = 8'h00;
    end else begin
      if (avm_chipselect && !avm_write_n) begin
        checkOutput("writeExpected", 32'(wrQ.size() != 0), 32'd1);
        if (wrQ.size() != 0) begin
          wrExp_t w;
          w = wrQ.pop_front();
          checkOutput("wrAddr", 32'(avm_address), 32'(w.addr));
          checkOutput("wrData", avm_writedata, w.data);
        end
        lastWriteCycle = cycleCount;
      end
      if (capQ.size() != 0 && capQ[0].due == cycleCount) begin
        capExp_t c;
        c = capQ.pop_front();
        checkOutput("capSample", 32'(sample), 32'(c.value));
        checkOutput("capSampleValid", 32'(sample_valid), 32'd1);
        checkOutput("capEvtValid", 32'(evt_valid), 32'(c.evtExp));
        if (c.prevValid) begin
          checkOutput("capEvtRise", 32'(evt_rise), 32'(c.rise));
          checkOutput("capEvtFall", 32'(evt_fall), 32'(c.fall));
        end
      end else begin
        checkOutput("evtIdle", 32'(evt_valid), 32'd0);
      end
      if (avm_chipselect && avm_write_n) begin
        capExp_t n;
        n.due       = cycleCount + 2;
        n.value     = pinValue;
        n.prevValid = modelValid;
        n.evtExp    = modelValid && (pinValue != modelSample);
        n.rise      = pinValue & ~modelSample;
        n.fall      = ~pinValue & modelSample;
        capQ.push_back(n);
        modelSample   = pinValue;
        modelValid    = 1'b1;
        readCount     = readCount + 1;
        lastReadCycle = cycleCount;
      end
      if (evt_valid) evtCount = evtCount + 1;
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data);
    int w;
    wrExp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    e.addr    = tbAddr(op);
    e.data    = {24'h0, data};
    wrQ.push_back(e);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("cmdAccept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic setPins(input logic [7:0] v);
    @(posedge clk);
    #1 pinValue = v;
  endtask

  task automatic waitRead(output int cyc);
    int start;
    int w;
    start = readCount;
    w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (readCount == start && w < 60);
    checkOutput("readSeen", 32'(readCount != start), 32'd1);
    cyc = lastReadCycle;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, r1, r2, r3, r4, a1, w;
    wrExp_t initW;

    repeat (2) @(negedge clk);
    checkOutput("rstChipselect", 32'(avm_chipselect), 32'd0);
    checkOutput("rstWriteN", 32'(avm_write_n), 32'd1);
    checkOutput("rstAddress", 32'(avm_address), 32'd0);
    checkOutput("rstWritedata", avm_writedata, 32'd0);
    checkOutput("rstCmdReady", 32'(cmd_ready), 32'd0);
    checkOutput("rstSample", 32'(sample), 32'd0);
    checkOutput("rstSampleValid", 32'(sample_valid), 32'd0);
    checkOutput("rstEvt", {8'h0, evt_rise, evt_fall, 7'h0, evt_valid}, 32'd0);

    initW.addr = 3'd1;
    initW.data = {24'h0, RESET_DIR};
    wrQ.push_back(initW);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("initCmdReady", 32'(cmd_ready), 32'd0);
    checkOutput("initChipselect", 32'(avm_chipselect), 32'd1);
    @(negedge clk);
    checkOutput("readyAfterInit", 32'(cmd_ready), 32'd1);
    checkOutput("initWriteDone", 32'(wrQ.size()), 32'd0);

    applyStimulus(2'd2, 8'h81);
    @(negedge clk);
    checkOutput("readyLowInWrite", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("readyBackHigh", 32'(cmd_ready), 32'd1);

    applyStimulus(2'd0, 8'h3C);
    a1 = cycleCount;
    applyStimulus(2'd3, 8'h11);
    checkOutput("backToBackSpacing", 32'(cycleCount - a1), 32'd2);
    applyStimulus(2'd1, 8'hF0);
    repeat (2) @(negedge clk);
    checkOutput("cmdWritesDone", 32'(wrQ.size()), 32'd0);

    setPins(8'h00);
    poll_en = 1'b1;
    waitRead(r);
    repeat (3) @(negedge clk);
    checkOutput("firstPollValid", 32'(sample_valid), 32'd1);
    checkOutput("firstPollNoEvt", 32'(evtCount), 32'd0);

    setPins(8'h05);
    waitRead(r);
    repeat (3) @(negedge clk);
    setPins(8'h04);
    waitRead(r);
    repeat (3) @(negedge clk);
    waitRead(r);
    repeat (3) @(negedge clk);
    checkOutput("edgeEventCount", 32'(evtCount), 32'd2);

    waitRead(r1);
    waitRead(r2);
    checkOutput("pollSpacing", 32'(r2 - r1), 32'(POLL_DIV));

    waitRead(r);
    w = 0;
    while (cycleCount != r + 7 && w < 40) begin
      @(negedge clk);
      w++;
    end
    applyStimulus(2'd0, 8'hA5);
    @(negedge clk);
    #1;
    checkOutput("collisionWriteCycle", 32'(lastWriteCycle - r), 32'd8);
    waitRead(r3);
    checkOutput("collisionReadCycle", 32'(r3 - r), 32'd10);
    waitRead(r4);
    checkOutput("nextReadCycle", 32'(r4 - r), 32'(2 * POLL_DIV));

    w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (!(avm_chipselect && avm_write_n) && w < 40);
    checkOutput("inReadCycle", 32'(avm_chipselect && avm_write_n), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstChipselect", 32'(avm_chipselect), 32'd0);
    checkOutput("midRstSampleValid", 32'(sample_valid), 32'd0);
    checkOutput("midRstCmdReady", 32'(cmd_ready), 32'd0);
    repeat (2) @(posedge clk);
    wrQ.push_back(initW);
    #1 reset_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reInitWrite", 32'(wrQ.size()), 32'd0);
    waitRead(r);
    repeat (3) @(negedge clk);
    checkOutput("postRstValid", 32'(sample_valid), 32'd1);
    checkOutput("postRstSample", 32'(sample), 32'h04);
    checkOutput("postRstNoEvt", 32'(evtCount), 32'd2);
    checkOutput("allWritesSeen", 32'(wrQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
